fx_addsub_pipe: RTL
===================

Name: fx_addsub_pipe

Overview:
- Parametrised fixed-point adder/subtractor, the successor to the fixed-format subtract+delay blocks.
- Generalises input and output widths and fractional bits, with add/sub selectable per sample.
- Adds round/truncate, saturate/wrap, valid qualification, a configurable pipeline depth, and overflow flagging/counting.
- Instantiated in datapaths wherever two signed Q-format streams are combined.

Parameters:
- IN1_W, 12, total width of i_data_1 (signed two's complement)
- IN1_FRAC, 8, fractional bits of i_data_1
- IN2_W, 12, total width of i_data_2
- IN2_FRAC, 8, fractional bits of i_data_2
- OUT_W, 13, total width of o_data
- OUT_FRAC, 8, fractional bits of o_data
- LATENCY, 2, cycles from i_valid to o_valid; legal range 1 to 16
- SAT_EN, 1, 1 = saturate on integer overflow, 0 = wrap
- ROUND_EN, 1, 1 = round half toward +inf when dropping fraction bits, 0 = truncate (floor)
- CNT_W, 16, width of the overflow event counter

Ports:
- i_clk  in  1  clock; all logic on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_valid  in  1  input sample qualifier
- i_sub  in  1  1 = i_data_1 - i_data_2, 0 = i_data_1 + i_data_2; sampled with i_valid
- i_data_1  in  IN1_W  operand 1, signed Q(IN1_W-IN1_FRAC).IN1_FRAC
- i_data_2  in  IN2_W  operand 2, signed Q(IN2_W-IN2_FRAC).IN2_FRAC
- i_ovf_clr  in  1  clears o_ovf_cnt
- o_valid  out  1  output sample qualifier
- o_data  out  OUT_W  result, signed Q(OUT_W-OUT_FRAC).OUT_FRAC
- o_ovf  out  1  overflow occurred on this output sample; qualified by o_valid
- o_ovf_cnt  out  CNT_W  count of overflowed samples; saturates at all-ones

Behaviour:
- Reset: the clock is i_clk; reset is synchronous and active-high on i_rst. While i_rst is high at a rising edge:
  - all pipeline valid bits, o_valid, o_data, o_ovf and o_ovf_cnt are set to 0;
  - in-flight samples are discarded;
  - i_valid is ignored during the reset cycle.
- Alignment:
  - FRAC_I = max(IN1_FRAC, IN2_FRAC).
  - INT_I = max(IN1_W-IN1_FRAC, IN2_W-IN2_FRAC) + 2, covering negation growth and sum growth.
  - Internal width is INT_I+FRAC_I. Both operands are sign-extended and left-shifted to FRAC_I.
- Subtract: operand 2 is negated after extension, so the most negative input is exact (-(-2048) = +2048).
- Conversion to output format:
  - FRAC_I > OUT_FRAC: drop D = FRAC_I-OUT_FRAC LSBs. With ROUND_EN=1, add 2^(D-1) before the arithmetic shift; with ROUND_EN=0, floor.
  - FRAC_I < OUT_FRAC: zero-pad the LSBs.
  - Integer range check happens after rounding. If the value is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1]:
    - SAT_EN=1: clamp to the nearest limit;
    - SAT_EN=0: keep the low OUT_W bits;
    - o_ovf=1 in both modes.
- Pipeline:
  - Stage 1 registers the converted result and ovf, with its valid bit.
  - A further LATENCY-1 register stages follow. o_valid is i_valid delayed by exactly LATENCY cycles.
  - Data registers in every stage load only when that stage's incoming valid=1. o_data/o_ovf therefore hold the last valid result while o_valid=0.
  - Full throughput: one sample per cycle, back-to-back, with no stall.
- Counter:
  - Increments when o_valid & o_ovf; holds at 2^CNT_W-1.
  - i_ovf_clr alone sets it to 0.
  - i_ovf_clr and a counted event in the same cycle set it to 1, so no event is lost.
- LATENCY outside 1..16 is a elaboration error (generate-time assertion).

Decomposition:
- Package fx_pkg holds:
  - function fx_max(a,b);
  - localparam derivations for INT_I, FRAC_I and D;
  - function fx_sat_limits(w) returning the max/min constants.
- Sub-module fx_convert (combinational): parameters for input width/frac and OUT_W/OUT_FRAC/SAT_EN/ROUND_EN; outputs data and ovf. It is reusable by other arithmetic blocks.
- The delay line is a generate loop inside fx_addsub_pipe.

Test Plan:
- Defaults, i_sub=1, 0x7FF - 0x800 -> two cycles later o_valid=1, o_data=0x0FFF, o_ovf=0, o_ovf_cnt=0.
- OUT_W=12, SAT_EN=1, add 0x7FF + 0x001 -> o_data=0x7FF, o_ovf=1, o_ovf_cnt=1. Add 0x800 + 0xFFF -> o_data=0x800, o_ovf=1, o_ovf_cnt=2.
- OUT_W=12, SAT_EN=0, add 0x7FF + 0x001 -> o_data=0x800 (wrapped), o_ovf=1.
- OUT_W=11, OUT_FRAC=6, add with second operand 0x000:
  - ROUND_EN=1: 0x003 -> o_data=0x001; 0xFFD -> o_data=0x7FF (-1).
  - ROUND_EN=0: 0x003 -> o_data=0x000.
- Defaults, i_valid at cycles 0, 1 and 3 (data 1+1, 2+2, 3+3), i_rst high at cycle 2:
  - only one o_valid pulse, at cycle 5, with o_data=0x006;
  - o_valid=0 at cycles 2, 3 and 4.
- CNT_W=2, OUT_W=12, SAT_EN=1, five consecutive overflowing samples -> o_ovf_cnt sequence 1, 2, 3, 3, 3. Then i_ovf_clr asserted in the same cycle as an overflowed output -> o_ovf_cnt=1; next cycle with no overflow -> holds 1.

Source files
------------

// File: rtl/fx_pkg.sv
// fx_pkg: shared helpers for signed fixed-point arithmetic blocks
//   fx_max        - larger of two integers
//   fx_frac_i     - internal fraction bits covering both operands
//   fx_int_i      - internal integer bits, +2 for negation and sum growth
//   fx_drop       - fraction LSBs dropped when converting to the output format
//   fx_sat_limits - largest and smallest value representable in a signed w-bit word
package fx_pkg;

    typedef struct packed {
        logic signed [63:0] hi;
        logic signed [63:0] lo;
    } fx_lim_t;

    function automatic int fx_max(int a, int b);
        return a > b ? a : b;
    endfunction

    function automatic int fx_frac_i(int f1, int f2);
        return fx_max(f1, f2);
    endfunction

    function automatic int fx_int_i(int w1, int f1, int w2, int f2);
        return fx_max(w1 - f1, w2 - f2) + 2;
    endfunction

    function automatic int fx_drop(int frac_in, int frac_out);
        return frac_in > frac_out ? frac_in - frac_out : 0;
    endfunction

    function automatic fx_lim_t fx_sat_limits(int w);
        fx_lim_t l;
        l.hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        l.lo = -(64'sd1 <<< (w - 1));
        return l;
    endfunction

endpackage

// File: rtl/fx_convert.sv
// fx_convert: combinational signed Q-format requantiser (round/floor, saturate/wrap)
//   din  in  IN_W   signed value with IN_FRAC fraction bits
//   dout out OUT_W  signed value with OUT_FRAC fraction bits
//   ovf  out 1      value did not fit the output integer range
module fx_convert
    import fx_pkg::*;
#(
    parameter int IN_W     = 14,
    parameter int IN_FRAC  = 8,
    parameter int OUT_W    = 13,
    parameter int OUT_FRAC = 8,
    parameter bit SAT_EN   = 1'b1,
    parameter bit ROUND_EN = 1'b1
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             ovf
);

    localparam int PAD = OUT_FRAC > IN_FRAC ? OUT_FRAC - IN_FRAC : 0;
    localparam int D   = fx_drop(IN_FRAC, OUT_FRAC);
    // One spare bit above the padded input absorbs the rounding increment,
    // and the work width always exceeds OUT_W so the range test is exact.
    localparam int CW  = fx_max(IN_W + PAD + 1, OUT_W + 1);
    localparam fx_lim_t LIM = fx_sat_limits(OUT_W);
    localparam logic signed [CW-1:0] HI  = CW'(LIM.hi);
    localparam logic signed [CW-1:0] LO  = CW'(LIM.lo);
    localparam logic signed [CW-1:0] RND = (ROUND_EN && D > 0) ? CW'(1) << (D > 0 ? D - 1 : 0) : '0;

    logic signed [CW-1:0] ext, rnd, sh;
    logic                 hi, lo;

    assign ext  = CW'($signed(din)) <<< PAD;
    assign rnd  = ext + RND;
    assign sh   = rnd >>> D;
    assign hi   = sh > HI;
    assign lo   = sh < LO;
    assign ovf  = hi | lo;
    assign dout = !SAT_EN ? sh[OUT_W-1:0] : hi ? HI[OUT_W-1:0] : lo ? LO[OUT_W-1:0] : sh[OUT_W-1:0];

endmodule

// File: rtl/fx_addsub_pipe.sv
// fx_addsub_pipe: pipelined signed fixed-point add/subtract with requantisation and overflow count
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid, i_sub      sample qualifier, 1 = subtract
//   i_data_1, i_data_2  signed Q-format operands
//   i_ovf_clr           clears the overflow counter
//   o_valid, o_data     result qualifier and value, LATENCY cycles after input
//   o_ovf, o_ovf_cnt    per-sample overflow flag and saturating event count
module fx_addsub_pipe
    import fx_pkg::*;
#(
    parameter int IN1_W    = 12,
    parameter int IN1_FRAC = 8,
    parameter int IN2_W    = 12,
    parameter int IN2_FRAC = 8,
    parameter int OUT_W    = 13,
    parameter int OUT_FRAC = 8,
    parameter int LATENCY  = 2,
    parameter bit SAT_EN   = 1'b1,
    parameter bit ROUND_EN = 1'b1,
    parameter int CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_sub,
    input  logic [IN1_W-1:0] i_data_1,
    input  logic [IN2_W-1:0] i_data_2,
    input  logic             i_ovf_clr,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_data,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_ovf_cnt
);

    localparam int FRAC_I = fx_frac_i(IN1_FRAC, IN2_FRAC);
    localparam int INT_I  = fx_int_i(IN1_W, IN1_FRAC, IN2_W, IN2_FRAC);
    localparam int IW     = INT_I + FRAC_I;

    if (LATENCY < 1 || LATENCY > 16) begin : g_bad_latency
        $error("fx_addsub_pipe: LATENCY must be 1..16");
    end

    logic signed [IW-1:0] a, b, sum;
    logic [OUT_W-1:0]     cd;
    logic                 co;

    // Negating after extension keeps -(most negative input) exact.
    assign a   = IW'($signed(i_data_1)) <<< (FRAC_I - IN1_FRAC);
    assign b   = IW'($signed(i_data_2)) <<< (FRAC_I - IN2_FRAC);
    assign sum = i_sub ? a - b : a + b;

    fx_convert #(
        .IN_W    (IW),
        .IN_FRAC (FRAC_I),
        .OUT_W   (OUT_W),
        .OUT_FRAC(OUT_FRAC),
        .SAT_EN  (SAT_EN),
        .ROUND_EN(ROUND_EN)
    ) u_convert (
        .din (sum),
        .dout(cd),
        .ovf (co)
    );

    for (genvar k = 0; k < LATENCY; k++) begin : stg
        logic             v, o, v_in, o_in;
        logic [OUT_W-1:0] d, d_in;
        if (k == 0) begin : g_head
            assign v_in = i_valid;
            assign d_in = cd;
            assign o_in = co;
        end else begin : g_tail
            assign v_in = stg[k-1].v;
            assign d_in = stg[k-1].d;
            assign o_in = stg[k-1].o;
        end
        // Data only moves with a valid sample so outputs hold between samples.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                v <= 1'b0;
                d <= '0;
                o <= 1'b0;
            end else begin
                v <= v_in;
                if (v_in) begin
                    d <= d_in;
                    o <= o_in;
                end
            end
        end
    end

    assign o_valid = stg[LATENCY-1].v;
    assign o_data  = stg[LATENCY-1].d;
    assign o_ovf   = stg[LATENCY-1].o;

    logic ev;
    assign ev = o_valid & o_ovf;

    // A clear coinciding with an event restarts at 1 so that event is kept.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_ovf_cnt <= '0;
        else if (i_ovf_clr)
            o_ovf_cnt <= CNT_W'(ev);
        else if (ev && !(&o_ovf_cnt))
            o_ovf_cnt <= o_ovf_cnt + 1'b1;
    end

endmodule
